// File: rtl/npc_pkg.sv
// Shared decode types for the NPC core: opcode constants, ALU/memory enums and
// the decoded-instruction bundle passed from decode to execute.
package npc_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [6:0]  F7_ZERO     = 7'b0000000;
  localparam logic [6:0]  F7_ALT      = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2,
    MEM_RSVD = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        src_a_pc;
    logic        src_b_imm;
    logic        reg_wen;
    logic        mem_ren;
    logic        mem_wen;
    mem_size_e   mem_size;
    logic        mem_sext;
    logic [2:0]  branch;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic        ebreak;
    logic        illegal;
  } decode_bundle_t;

  // Base ALU op for OP/OP-IMM with funct7 = 0; SUB/SRA are selected by funct7.
  function automatic alu_op_e alu_of_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/idu_decoder.sv
// Pure combinational RV32I/RV32E decoder. Illegal encodings collapse to an
// all-zero bundle with only the illegal flag set, so no enables can leak.
module idu_decoder
  import npc_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0]    inst_i,
  output decode_bundle_t dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        use_rs1, use_rs2, wr_rd, ill;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'b0};
  assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    dec_o   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    ill     = 1'b0;
    case (opcode)
      OP_LUI: begin
        dec_o.imm       = imm_u;
        dec_o.alu_op    = ALU_LUI;
        dec_o.src_b_imm = 1'b1;
        wr_rd           = 1'b1;
      end
      OP_AUIPC: begin
        dec_o.imm       = imm_u;
        dec_o.src_a_pc  = 1'b1;
        dec_o.src_b_imm = 1'b1;
        wr_rd           = 1'b1;
      end
      OP_JAL: begin
        dec_o.imm      = imm_j;
        dec_o.src_a_pc = 1'b1;
        dec_o.is_jal   = 1'b1;
        wr_rd          = 1'b1;
      end
      OP_JALR: begin
        dec_o.imm      = imm_i;
        dec_o.src_a_pc = 1'b1;
        dec_o.is_jalr  = 1'b1;
        wr_rd          = 1'b1;
        use_rs1        = 1'b1;
        ill            = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        dec_o.imm    = imm_b;
        dec_o.alu_op = ALU_SUB;
        dec_o.is_br  = 1'b1;
        dec_o.branch = f3;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        ill          = (f3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        dec_o.imm       = imm_i;
        dec_o.src_b_imm = 1'b1;
        dec_o.mem_ren   = 1'b1;
        dec_o.mem_size  = mem_size_e'(f3[1:0]);
        dec_o.mem_sext  = ~f3[2];
        wr_rd           = 1'b1;
        use_rs1         = 1'b1;
        ill             = (f3[1:0] == 2'b11) || (f3 == 3'b110);
      end
      OP_STORE: begin
        dec_o.imm       = imm_s;
        dec_o.src_b_imm = 1'b1;
        dec_o.mem_wen   = 1'b1;
        dec_o.mem_size  = mem_size_e'(f3[1:0]);
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        ill             = f3[2] || (f3[1:0] == 2'b11);
      end
      OP_IMM: begin
        dec_o.imm       = imm_i;
        dec_o.src_b_imm = 1'b1;
        dec_o.alu_op    = alu_of_f3(f3);
        use_rs1         = 1'b1;
        wr_rd           = 1'b1;
        // Shift-immediates reuse the top of imm as funct7; only SRAI may set bit 30.
        if (f3 == 3'b001) begin
          ill = (f7 != F7_ZERO);
        end else if (f3 == 3'b101) begin
          if (f7 == F7_ALT) dec_o.alu_op = ALU_SRA;
          else              ill = (f7 != F7_ZERO);
        end
      end
      OP_OP: begin
        dec_o.alu_op = alu_of_f3(f3);
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        wr_rd        = 1'b1;
        if (f7 == F7_ALT) begin
          if (f3 == 3'b000)      dec_o.alu_op = ALU_SUB;
          else if (f3 == 3'b101) dec_o.alu_op = ALU_SRA;
          else                   ill = 1'b1;
        end else if (f7 != F7_ZERO) begin
          ill = 1'b1;
        end
      end
      OP_MISC_MEM: begin
        // FENCE is a no-op on this in-order, single-master core.
      end
      OP_SYSTEM: begin
        dec_o.imm = imm_i;
        if (inst_i == EBREAK_INST) dec_o.ebreak = 1'b1;
        else                       ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase

    dec_o.rs1     = use_rs1 ? inst_i[19:15] : 5'd0;
    dec_o.rs2     = use_rs2 ? inst_i[24:20] : 5'd0;
    dec_o.reg_wen = wr_rd && (inst_i[11:7] != 5'd0);
    dec_o.rd      = dec_o.reg_wen ? inst_i[11:7] : 5'd0;

    if ((REG_AW < 5) && ((use_rs1 && inst_i[19]) || (use_rs2 && inst_i[24]) || (wr_rd && inst_i[11])))
      ill = 1'b1;

    if (ill) begin
      dec_o         = '0;
      dec_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/idu_stage.sv
// Decode stage: decodes the fetched instruction and registers it into a main
// output entry backed by a one-entry skid buffer so in_ready comes from a flop.
module idu_stage
  import npc_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [31:0]       out_imm,
  output logic [3:0]        out_alu_op,
  output logic              out_src_a_pc,
  output logic              out_src_b_imm,
  output logic              out_reg_wen,
  output logic              out_mem_ren,
  output logic              out_mem_wen,
  output logic [1:0]        out_mem_size,
  output logic              out_mem_sext,
  output logic [2:0]        out_branch,
  output logic              out_is_br,
  output logic              out_is_jal,
  output logic              out_is_jalr,
  output logic              out_ebreak,
  output logic              out_illegal
);

  decode_bundle_t  dec;
  decode_bundle_t  main_q, main_d, skid_q, skid_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic            accept, fire;

  idu_decoder #(.REG_AW(REG_AW)) u_dec (
    .inst_i (in_inst),
    .dec_o  (dec)
  );

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept    = in_valid & in_ready;
  assign fire      = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    main_pc_d    = main_pc_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so the only move is skid -> main on a fire.
      if (fire) begin
        main_d       = skid_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || fire) begin
      main_valid_d = accept;
      if (accept) begin
        main_d    = dec;
        main_pc_d = in_pc;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = dec;
      skid_pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q       <= '0;
      main_pc_q    <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_pc_q    <= main_pc_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_pc        = main_pc_q;
  assign out_rs1       = main_q.rs1[REG_AW-1:0];
  assign out_rs2       = main_q.rs2[REG_AW-1:0];
  assign out_rd        = main_q.rd[REG_AW-1:0];
  assign out_imm       = main_q.imm;
  assign out_alu_op    = main_q.alu_op;
  assign out_src_a_pc  = main_q.src_a_pc;
  assign out_src_b_imm = main_q.src_b_imm;
  assign out_reg_wen   = main_q.reg_wen;
  assign out_mem_ren   = main_q.mem_ren;
  assign out_mem_wen   = main_q.mem_wen;
  assign out_mem_size  = main_q.mem_size;
  assign out_mem_sext  = main_q.mem_sext;
  assign out_branch    = main_q.branch;
  assign out_is_br     = main_q.is_br;
  assign out_is_jal    = main_q.is_jal;
  assign out_is_jalr   = main_q.is_jalr;
  assign out_ebreak    = main_q.ebreak;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: expected bundles are queued on accept and
// compared on each output handshake; an RV32E instance checks register limits.
module tb_idu_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [15:0] fl;
    logic        ill4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_op;
  logic        out_src_a_pc, out_src_b_imm, out_reg_wen, out_mem_ren, out_mem_wen, out_mem_sext;
  logic [1:0]  out_mem_size;
  logic [2:0]  out_branch;
  logic        out_is_br, out_is_jal, out_is_jalr, out_ebreak, out_illegal;

  logic        e_in_ready, e_out_valid;
  logic [31:0] e_out_pc, e_out_imm;
  logic [3:0]  e_out_rs1, e_out_rs2, e_out_rd;
  logic [3:0]  e_out_alu_op;
  logic        e_src_a_pc, e_src_b_imm, e_reg_wen, e_mem_ren, e_mem_wen, e_mem_sext;
  logic [1:0]  e_mem_size;
  logic [2:0]  e_branch;
  logic        e_is_br, e_is_jal, e_is_jalr, e_ebreak, e_illegal;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  idu_stage #(.REG_AW(5), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_src_a_pc(out_src_a_pc), .out_src_b_imm(out_src_b_imm),
    .out_reg_wen(out_reg_wen), .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
    .out_mem_size(out_mem_size), .out_mem_sext(out_mem_sext), .out_branch(out_branch),
    .out_is_br(out_is_br), .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr),
    .out_ebreak(out_ebreak), .out_illegal(out_illegal)
  );

  idu_stage #(.REG_AW(4), .XLEN(32)) dut_e (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc),
    .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd), .out_imm(e_out_imm),
    .out_alu_op(e_out_alu_op), .out_src_a_pc(e_src_a_pc), .out_src_b_imm(e_src_b_imm),
    .out_reg_wen(e_reg_wen), .out_mem_ren(e_mem_ren), .out_mem_wen(e_mem_wen),
    .out_mem_size(e_mem_size), .out_mem_sext(e_mem_sext), .out_branch(e_branch),
    .out_is_br(e_is_br), .out_is_jal(e_is_jal), .out_is_jalr(e_is_jalr),
    .out_ebreak(e_ebreak), .out_illegal(e_illegal)
  );

  // Flag order: a_pc b_imm wen ren mwen size[1:0] sext branch[2:0] is_br jal jalr ebreak illegal
  function automatic logic [15:0] F(input logic a_pc, b_imm, wen, ren, mwen,
                                    input logic [1:0] size, input logic sext,
                                    input logic [2:0] br, input logic isbr, jal, jalr, ebr, ill);
    return {a_pc, b_imm, wen, ren, mwen, size, sext, br, isbr, jal, jalr, ebr, ill};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                              input logic [31:0] imm, input logic [3:0] alu,
                              input logic [15:0] fl, input logic ill4);
    exp_t e;
    e = '{pc: pc, rs1: rs1, rs2: rs2, rd: rd, imm: imm, alu: alu, fl: fl, ill4: ill4};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic put(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    cur      = e;
  endtask

  // One clock: scoreboard work on the falling edge, then settle past the rising edge.
  task automatic tick();
    exp_t e;
    logic [19:0] ctrl;
    @(negedge clk);
    if (!rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          ctrl = {out_alu_op, out_src_a_pc, out_src_b_imm, out_reg_wen, out_mem_ren, out_mem_wen,
                  out_mem_size, out_mem_sext, out_branch, out_is_br, out_is_jal, out_is_jalr,
                  out_ebreak, out_illegal};
          chk("pc", 64'(out_pc), 64'(e.pc));
          chk("regs", 64'({out_rs1, out_rs2, out_rd}), 64'({e.rs1, e.rs2, e.rd}));
          chk("imm", 64'(out_imm), 64'(e.imm));
          chk("ctrl", 64'(ctrl), 64'({e.alu, e.fl}));
          chk("rv32e_illegal", 64'(e_illegal), 64'(e.ill4));
          $display("out pc=%h rd=%0d imm=%h alu=%0d illegal=%0d", out_pc, out_rd, out_imm, out_alu_op, out_illegal);
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] FL_ALU_IMM = 16'b0110_0000_0000_0000;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 32'h0; cur = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    rst = 1'b1;
    tick();

    // addi x1,x0,5
    put(32'h0050_0093, 32'h100, mk(32'h100, 5'd0, 5'd0, 5'd1, 32'd5, 4'd0, FL_ALU_IMM, 1'b0));
    tick();
    in_valid = 1'b0;
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_rd", 64'(out_rd), 64'd1);
    tick();

    // Back-to-back stream with out_ready held high.
    put(32'hFFC0_A103, 32'h104, mk(32'h104, 5'd1, 5'd0, 5'd2, 32'hFFFF_FFFC, 4'd0,
        F(0,1,1,1,0,2'd2,1,3'd0,0,0,0,0,0), 1'b0));                       // lw x2,-4(x1)
    tick();
    put(32'hFE20_AC23, 32'h108, mk(32'h108, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 4'd0,
        F(0,1,0,0,1,2'd2,0,3'd0,0,0,0,0,0), 1'b0));                       // sw x2,-8(x1)
    tick();
    put(32'hFE20_8CE3, 32'h10C, mk(32'h10C, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 4'd1,
        F(0,0,0,0,0,2'd0,0,3'd0,1,0,0,0,0), 1'b0));                       // beq x1,x2,-8
    tick();
    put(32'h0100_00EF, 32'h110, mk(32'h110, 5'd0, 5'd0, 5'd1, 32'd16, 4'd0,
        F(1,0,1,0,0,2'd0,0,3'd0,0,1,0,0,0), 1'b0));                       // jal x1,16
    tick();
    put(32'h4032_D393, 32'h114, mk(32'h114, 5'd5, 5'd0, 5'd7, 32'h403, 4'd7,
        FL_ALU_IMM, 1'b0));                                               // srai x7,x5,3
    tick();
    put(32'h4032_9393, 32'h118, mk(32'h118, 5'd0, 5'd0, 5'd0, 32'h0, 4'd0,
        F(0,0,0,0,0,2'd0,0,3'd0,0,0,0,0,1), 1'b1));                       // slli with funct7=0100000
    tick();
    put(32'h0000_0000, 32'h11C, mk(32'h11C, 5'd0, 5'd0, 5'd0, 32'h0, 4'd0,
        F(0,0,0,0,0,2'd0,0,3'd0,0,0,0,0,1), 1'b1));                       // all-zero word
    tick();
    put(32'h0010_0073, 32'h120, mk(32'h120, 5'd0, 5'd0, 5'd0, 32'd1, 4'd0,
        F(0,0,0,0,0,2'd0,0,3'd0,0,0,0,1,0), 1'b0));                       // ebreak
    tick();
    put(32'h0020_8833, 32'h124, mk(32'h124, 5'd1, 5'd2, 5'd16, 32'h0, 4'd0,
        F(0,0,1,0,0,2'd0,0,3'd0,0,0,0,0,0), 1'b1));                       // add x16,x1,x2
    tick();
    in_valid = 1'b0;
    tick(); tick();

    // Backpressure: A in main, B in skid, then drain in order.
    out_ready = 1'b0;
    put(32'h1234_52B7, 32'h200, mk(32'h200, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 4'd10,
        FL_ALU_IMM, 1'b0));                                               // lui x5,0x12345
    tick();
    put(32'h4012_8333, 32'h204, mk(32'h204, 5'd5, 5'd1, 5'd6, 32'h0, 4'd1,
        F(0,0,1,0,0,2'd0,0,3'd0,0,0,0,0,0), 1'b0));                       // sub x6,x5,x1
    tick();
    in_valid = 1'b0;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("stall_pc_a", 64'(out_pc), 64'h200);
    tick();
    chk("stall_hold_pc", 64'(out_pc), 64'h200);
    chk("stall_hold_imm", 64'(out_imm), 64'h1234_5000);
    out_ready = 1'b1;
    tick();
    chk("drain_valid_b", 64'(out_valid), 64'd1);
    chk("drain_pc_b", 64'(out_pc), 64'h204);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Flush while both entries are held, with a new instruction offered.
    out_ready = 1'b0;
    put(32'h0010_0193, 32'h300, mk(32'h300, 5'd0, 5'd0, 5'd3, 32'd1, 4'd0, FL_ALU_IMM, 1'b0));
    tick();
    put(32'h0020_0213, 32'h304, mk(32'h304, 5'd0, 5'd0, 5'd4, 32'd2, 4'd0, FL_ALU_IMM, 1'b0));
    tick();
    flush = 1'b1;
    put(32'h0030_0293, 32'h308, mk(32'h308, 5'd0, 5'd0, 5'd5, 32'd3, 4'd0, FL_ALU_IMM, 1'b0));
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick(); tick();

    // Reset in the middle of a stall.
    out_ready = 1'b0;
    put(32'h0010_0193, 32'h400, mk(32'h400, 5'd0, 5'd0, 5'd3, 32'd1, 4'd0, FL_ALU_IMM, 1'b0));
    tick();
    put(32'h0020_0213, 32'h404, mk(32'h404, 5'd0, 5'd0, 5'd4, 32'd2, 4'd0, FL_ALU_IMM, 1'b0));
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_data", 64'({out_pc, out_imm}), 64'd0);
    chk("mrst_rd_wen", 64'({out_rd, out_reg_wen}), 64'd0);
    out_ready = 1'b1;
    tick(); tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
